// File: rtl/barrel_shifter_seq_l_16b_pkg.sv
// Shared constants and state encoding for the sequential 16-bit left rotator.
package barrel_pkg;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;
   localparam int AMT_W  = $clog2(WIDTH);
   localparam int IDX_W  = $clog2(STAGES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/barrel_shifter_seq_l_16b_if.sv
// Start/ready request and done/result response bundle of the left rotator.
interface barrel_shifter_seq_l_16b_if;
   import barrel_pkg::*;

   logic             start;
   logic [WIDTH-1:0] a;
   logic [AMT_W-1:0] amt;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] y;

   modport master (output start, a, amt, input ready, busy, done, y);
   modport slave  (input start, a, amt, output ready, busy, done, y);

endinterface

// File: rtl/barrel_shifter_seq_l_16b_rotl_stage.sv
// One logarithmic rotate stage: rotates x left by 2^k when en, else passes x.
module rotl_stage_16b
   import barrel_pkg::*;
(
   input  logic [WIDTH-1:0] x,
   input  logic [IDX_W-1:0] k,
   input  logic             en,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = x;
      if (en) begin
         case (k)
            2'd0:    y = {x[14:0], x[15]};
            2'd1:    y = {x[13:0], x[15:14]};
            2'd2:    y = {x[11:0], x[15:12]};
            default: y = {x[7:0],  x[15:8]};
         endcase
      end
   end

endmodule

// File: rtl/barrel_shifter_seq_l_16b.sv
// Sequential 16-bit left rotator: one rotate stage per clock, 4 SHIFT cycles per operation.
module barrel_shifter_seq_l_16b
   import barrel_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   barrel_shifter_seq_l_16b_if.slave bus
);

   state_t           state, next_state;
   logic [WIDTH-1:0] work;
   logic [AMT_W-1:0] amt_r;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] y_r;
   logic [WIDTH-1:0] stage_out;
   logic             ready, busy, done, accept, last;

   // Single stage instance reused on every SHIFT cycle, selected by idx.
   rotl_stage_16b u_stage (
      .x  (work),
      .k  (idx),
      .en (amt_r[idx]),
      .y  (stage_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      ready      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            ready  = 1'b1;
            accept = bus.start;
            if (bus.start) next_state = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            last = (idx == 2'd3);
            if (idx == 2'd3) next_state = DONE;
         end
         DONE: begin
            ready      = 1'b1;
            done       = 1'b1;
            accept     = bus.start;
            next_state = bus.start ? SHIFT : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         work  <= '0;
         amt_r <= '0;
         idx   <= '0;
         y_r   <= '0;
      end else if (accept) begin
         work  <= bus.a;
         amt_r <= bus.amt;
         idx   <= '0;
      end else if (busy) begin
         work <= stage_out;
         idx  <= idx + 2'd1;
         if (last) y_r <= stage_out;
      end
   end

   assign bus.ready = ready;
   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.y     = y_r;

endmodule
